subckt_bist_ctrl: RTL and testbench
===================================

# subckt_bist_ctrl

Built-in self-test sequencer for one trojan-detection subcircuit (3 data inputs, 1 registered output). It drives pseudo-random patterns into the subcircuit from an LFSR and compacts the subcircuit output into a MISR signature. After a fixed pattern count and pipeline flush, it compares the signature against a golden value. It sits between the test-access logic (start/abort/golden) and a single subcircuit instance, sharing that instance's clock and reset.

## Interface
- N_PATTERNS, 256: patterns applied per run (2..65535).
- LAT, 2: cycles from `dut_in` change to the corresponding `dut_out` sample (1..8).
- W, 16: LFSR and MISR width.
- SEED, 16'hACE1: LFSR load value (nonzero).
- POLY, 16'h1021: MISR feedback polynomial.

Ports:
- I1470_clk  in  1  clock, rising edge.
- I1477_rst  in  1  reset; **one clock; reset is asynchronous and active-low**.
- start  in  1  one-cycle run request; honoured in IDLE and DONE only.
- abort  in  1  synchronous; RUN/FLUSH → IDLE.
- golden_sig  in  W  expected signature, sampled on DONE entry.
- dut_out  in  1  subcircuit output.
- dut_in  out  3  subcircuit inputs {in2,in1,in0}.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  high in DONE.
- pass  out  1  signature==golden_sig, valid while done.
- signature  out  W  MISR contents.
- pat_cnt  out  16  patterns applied in the current or last run.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE. All outputs are registered or decoded from state.
- Reset values: state=IDLE, lfsr=0, misr=0, pat_cnt=0, vld=0, flush_cnt=0. Outputs: dut_in=0, busy=0, done=0, pass=0, signature=0.
- IDLE/DONE with start=1: lfsr←SEED, misr←0, pat_cnt←0, vld←0, pass←0, state←RUN.
- RUN, each cycle:
  - dut_in=lfsr[2:0].
  - lfsr advances as a Fibonacci shift-left: new bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - pat_cnt+1.
  - vld shifts in 1.
  - When pat_cnt==N_PATTERNS-1 (last pattern applied this cycle): state←FLUSH, flush_cnt←0.
- FLUSH:
  - dut_in=0, vld shifts in 0, flush_cnt+1.
  - When flush_cnt==LAT-1: state←DONE, pass←(misr_next==golden_sig), where misr_next includes the final absorbed bit.
- MISR, any state, when vld[LAT-1]=1: misr←({misr[W-2:0],1'b0} ^ (misr[W-1]?POLY:0)) ^ {{W-1{0}},dut_out}. Otherwise it holds.
  - The MISR absorbs exactly N_PATTERNS bits per completed run.
- DONE: holds signature, pass and pat_cnt until start or reset.
- Abort in RUN/FLUSH: state←IDLE, vld←0, dut_in→0, done=0, pass=0. Signature and pat_cnt freeze at their current values.
- start in RUN/FLUSH is ignored. Abort in IDLE/DONE is ignored.
- start and abort in the same cycle:
  - In IDLE/DONE, start wins.
  - In RUN/FLUSH, abort wins.
- Counter widths: pat_cnt is 16 bits and never wraps, because N_PATTERNS ≤ 65535.
- Reset mid-run asserts immediately, regardless of clock; no partial signature survives.

## Timing
- start sampled at edge k → RUN from k; first pattern (SEED[2:0]=3'b001) on dut_in during cycle k+1.
- RUN lasts N_PATTERNS cycles, FLUSH lasts LAT cycles. done rises N_PATTERNS+LAT cycles after the start edge.
- The dut_out value sampled LAT cycles after a pattern's edge belongs to that pattern.
- Restart from DONE: done falls the cycle after start, busy rises together with it.
- Reset deassertion is assumed synchronised externally; the first active edge is treated as normal.

## Test plan
- Reset: assert I1477_rst=0 mid-RUN → all outputs 0 immediately; state IDLE after release; dut_in=0.
- Nominal: N_PATTERNS=4, LAT=2, dut_out tied 0, golden_sig=0 → dut_in sequence starts 001; done after 6 cycles; pass=1; pat_cnt=4.
- Known signature: N_PATTERNS=4, dut_out tied 1 → signature=16'h000F; golden 16'h000F gives pass=1, golden 16'h000E gives pass=0.
- Real subcircuit: N_PATTERNS=256 against the golden model → signature matches the model. Flipping one subcircuit gate gives pass=0.
- Control: start pulsed mid-RUN → ignored, done at the nominal cycle. Abort at pat_cnt=2 → IDLE next cycle, busy=0, done=0, pat_cnt=3.
- Determinism: two back-to-back runs started from DONE → identical signature, pass and done timing.

Source files
------------

// File: rtl/subckt_bist_ctrl.sv
// subckt_bist_ctrl: LFSR pattern generator and MISR compactor that self-tests one registered 3-input subcircuit
module subckt_bist_ctrl #(
  parameter int N_PATTERNS = 256,
  parameter int LAT = 2,
  parameter int W = 16,
  parameter logic [W-1:0] SEED = 16'hACE1,
  parameter logic [W-1:0] POLY = 16'h1021
) (
  input  logic         I1470_clk,
  input  logic         I1477_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] golden_sig,
  input  logic         dut_out,
  output logic [2:0]   dut_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W-1:0] signature,
  output logic [15:0]  pat_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] lfsr, misr, misr_nx;
  logic [LAT-1:0] vld, vld_nx;
  logic [3:0] flush_cnt;
  logic run, flush, launch, kill, last_pat, last_flush;
  always_comb begin
    run = state == RUN;
    flush = state == FLUSH;
    launch = start && (state == IDLE || state == DONE);
    kill = abort && (run || flush);
    last_pat = run && pat_cnt == 16'(N_PATTERNS - 1);
    last_flush = flush && flush_cnt == 4'(LAT - 1);
    misr_nx = vld[LAT-1] ? ({misr[W-2:0], 1'b0} ^ (misr[W-1] ? POLY : '0)) ^ {{(W-1){1'b0}}, dut_out} : misr;
    vld_nx = '0;
    vld_nx[0] = run;
    for (int i = 1; i < LAT; i++) vld_nx[i] = vld[i-1];
    state_nx = launch ? RUN : kill ? IDLE : last_pat ? FLUSH : last_flush ? DONE : state;
  end
  always_ff @(posedge I1470_clk or negedge I1477_rst)
    if (!I1477_rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge I1470_clk or negedge I1477_rst)
    if (!I1477_rst) begin
      lfsr <= '0;
      misr <= '0;
      pat_cnt <= '0;
      vld <= '0;
      flush_cnt <= '0;
      dut_in <= '0;
      pass <= 1'b0;
    end else if (launch) begin
      lfsr <= SEED;
      misr <= '0;
      pat_cnt <= '0;
      vld <= '0;
      flush_cnt <= '0;
      dut_in <= '0;
      pass <= 1'b0;
    end else begin
      misr <= misr_nx;
      // the aborting RUN edge still counts its pattern; everything stops afterwards
      if (run) pat_cnt <= pat_cnt + 16'd1;
      if (kill) begin
        vld <= '0;
        dut_in <= '0;
        pass <= 1'b0;
      end else if (run) begin
        dut_in <= lfsr[2:0];
        lfsr <= {lfsr[W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        vld <= vld_nx;
        flush_cnt <= '0;
      end else if (flush) begin
        dut_in <= '0;
        vld <= vld_nx;
        flush_cnt <= flush_cnt + 4'd1;
        if (last_flush) pass <= misr_nx == golden_sig;
      end
    end
  assign busy = state == RUN || state == FLUSH;
  assign done = state == DONE;
  assign signature = misr;
endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// tb_subckt_bist_ctrl: directed and randomized checks of the BIST sequencer against a pattern-level model
module tb_subckt_bist_ctrl;
  localparam int NA = 4, NB = 256, LAT = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start_a = 0, abort_a = 0, out_a = 0;
  logic [15:0] gold_a = 0;
  logic [2:0] in_a;
  logic busy_a, done_a, pass_a;
  logic [15:0] sig_a, cnt_a;
  logic start_b = 0, abort_b = 0, out_b, sub_q, fault = 0;
  logic [15:0] gold_b = 0;
  logic [2:0] in_b;
  logic busy_b, done_b, pass_b;
  logic [15:0] sig_b, cnt_b;
  int total = 0, bad = 0;
  subckt_bist_ctrl #(.N_PATTERNS(NA), .LAT(LAT)) u_a (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_a), .abort(abort_a), .golden_sig(gold_a),
    .dut_out(out_a), .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a));
  subckt_bist_ctrl #(.N_PATTERNS(NB), .LAT(LAT)) u_b (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_b), .abort(abort_b), .golden_sig(gold_b),
    .dut_out(out_b), .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b));
  function automatic logic subf(logic [2:0] x, logic flt);
    return flt ? ((x[2] | x[1]) ^ x[0]) : ((x[2] & x[1]) ^ x[0]);
  endfunction
  always @(posedge clk) sub_q <= subf(in_b, fault);
  assign out_b = sub_q;
  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic logic [15:0] misr_step(logic [15:0] m, logic b);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_a(input int mode, input logic [15:0] gold, input bit poke);
    logic [15:0] l, m;
    logic b;
    l = 16'hACE1;
    m = 16'h0;
    gold_a = gold;
    start_a = 1;
    tick;
    start_a = 0;
    chk("a_start_busy", busy_a, 1);
    chk("a_start_done", done_a, 0);
    chk("a_start_cnt", cnt_a, 0);
    chk("a_start_sig", sig_a, 0);
    chk("a_start_pass", pass_a, 0);
    for (int c = 1; c <= NA + LAT; c++) begin
      b = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : 1'($urandom);
      out_a = b;
      start_a = poke && c == 2;
      tick;
      if (c > LAT) m = misr_step(m, b);
      if (c <= NA) begin
        chk("a_pattern", in_a, l[2:0]);
        l = lfsr_step(l);
      end else chk("a_flush_in", in_a, 0);
      chk("a_busy", busy_a, c < NA + LAT);
      chk("a_done", done_a, c == NA + LAT);
      chk("a_cnt", cnt_a, c < NA ? c : NA);
      chk("a_sig_run", sig_a, m);
    end
    start_a = 0;
    chk("a_pass", pass_a, m == gold);
    out_a = 1'($urandom);
    tick;
    tick;
    chk("a_hold_done", done_a, 1);
    chk("a_hold_sig", sig_a, m);
    chk("a_hold_cnt", cnt_a, NA);
    chk("a_hold_pass", pass_a, m == gold);
  endtask
  task automatic run_b(input logic flt);
    logic [15:0] l, good, m;
    int n;
    l = 16'hACE1;
    good = 0;
    m = 0;
    for (int p = 1; p <= NB; p++) begin
      good = misr_step(good, subf(l[2:0], 1'b0));
      m = misr_step(m, subf(l[2:0], flt));
      l = lfsr_step(l);
    end
    gold_b = good;
    fault = flt;
    start_b = 1;
    tick;
    start_b = 0;
    n = 0;
    while (!done_b && n < 1000) begin
      tick;
      n++;
    end
    chk("b_done_time", n, NB + LAT);
    chk("b_sig", sig_b, m);
    chk("b_pass", pass_b, m == good);
    chk("b_cnt", cnt_b, NB);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_in", in_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1;
    tick;
    run_a(0, 16'h0000, 0);
    chk("nom_sig_zero", sig_a, 16'h0000);
    run_a(1, 16'h000F, 0);
    chk("ones_sig", sig_a, 16'h000F);
    chk("ones_pass", pass_a, 1);
    run_a(1, 16'h000E, 0);
    chk("ones_fail_pass", pass_a, 0);
    for (int r = 0; r < 6; r++) run_a(2, 16'($urandom_range(0, 3)), r[0]);
    abort_a = 1;
    tick;
    abort_a = 0;
    chk("done_abort_ignored", done_a, 1);
    out_a = 0;
    start_a = 1;
    tick;
    start_a = 0;
    tick;
    tick;
    chk("ab_cnt2", cnt_a, 2);
    abort_a = 1;
    tick;
    abort_a = 0;
    chk("ab_busy", busy_a, 0);
    chk("ab_done", done_a, 0);
    chk("ab_cnt", cnt_a, 3);
    chk("ab_in", in_a, 0);
    chk("ab_pass", pass_a, 0);
    tick;
    tick;
    chk("ab_cnt_frozen", cnt_a, 3);
    chk("ab_sig_frozen", sig_a, 0);
    chk("ab_idle", busy_a, 0);
    start_a = 1;
    abort_a = 1;
    tick;
    chk("both_idle_start_wins", busy_a, 1);
    start_a = 0;
    abort_a = 0;
    tick;
    start_a = 1;
    abort_a = 1;
    tick;
    start_a = 0;
    abort_a = 0;
    chk("both_run_abort_wins", busy_a, 0);
    out_a = 1;
    start_a = 1;
    tick;
    start_a = 0;
    repeat (4) tick;
    chk("pre_rst_sig", sig_a, 16'h0003);
    #2 rst_n = 0;
    #1;
    chk("async_in", in_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_done", done_a, 0);
    chk("async_pass", pass_a, 0);
    chk("async_sig", sig_a, 0);
    chk("async_cnt", cnt_a, 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick;
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_in", in_a, 0);
    run_a(2, 16'h0001, 0);
    run_b(0);
    run_b(1);
    run_b(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
